// File: rtl/nios2_pio_in_edge_pkg.sv
// Shared constants and edge-detect helper for the edge-capturing input PIO.
package nios2_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 32'sd0;
    localparam int EDGE_FALL = 32'sd1;
    localparam int EDGE_ANY  = 32'sd2;

    function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                                input logic [31:0] prev,
                                                input int          mode);
        logic [31:0] res;
        res = 32'h0;
        case (mode)
            EDGE_RISE: res = cur & ~prev;
            EDGE_FALL: res = ~cur & prev;
            EDGE_ANY:  res = cur ^ prev;
            default:   res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/nios2_pio_in_edge_if.sv
// Avalon-MM s1 slave bus plus the level interrupt line.
interface nios2_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata, irq);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata, irq);
endinterface

// File: rtl/nios2_pio_in_edge_sync.sv
// Multi-flop synchroniser for the external input bus, plus one delay stage
// that the edge detector compares against.
module nios2_pio_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_d
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];
    logic [WIDTH-1:0] delay_r;

    // Shift the input through the synchroniser chain and the delay flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
            delay_r <= {WIDTH{1'b0}};
        end else begin
            stage_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            delay_r <= stage_r[SYNC_STAGES-1];
        end
    end

    assign sync_in = stage_r[SYNC_STAGES-1];
    assign sync_d  = delay_r;

endmodule

// File: rtl/nios2_pio_in_edge.sv
// Avalon-MM input PIO with synchronised data register, per-bit edge capture,
// interrupt mask and a registered level IRQ.
module nios2_pio_in_edge
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_EN      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    nios2_pio_in_edge_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port
);

    localparam logic [2:0] PRIME_SAT = 3'(SYNC_STAGES + 1);
    localparam bit         IRQ_ON    = (IRQ_EN != 32'sd0);

    logic [WIDTH-1:0] sync_in_s;
    logic [WIDTH-1:0] sync_d_s;
    logic [WIDTH-1:0] edge_s;
    logic [31:0]      edge_all_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] cap_next_s;
    logic [WIDTH-1:0] mask_next_s;
    logic [31:0]      rd_next_s;
    logic             irq_next_s;
    logic             wr_s;
    logic             primed_s;

    logic [2:0]       prime_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] mask_r;
    logic [31:0]      rd_r;
    logic             irq_r;

    wire unused_wdata_s = ^bus.writedata;

    nios2_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .sync_in (sync_in_s),
        .sync_d  (sync_d_s)
    );

    assign primed_s = (prime_r == PRIME_SAT);
    assign wr_s     = bus.chipselect & ~bus.write_n;

    // Edge detection is held off until the synchroniser holds post-reset data,
    // so inputs already high at reset never register as edges.
    always_comb begin
        edge_all_s = edge_detect(32'(sync_in_s), 32'(sync_d_s), EDGE_TYPE);
        if (primed_s) begin
            edge_s = edge_all_s[WIDTH-1:0];
        end else begin
            edge_s = {WIDTH{1'b0}};
        end
    end

    // Capture/mask next state; a new edge beats a simultaneous clear.
    always_comb begin
        if (wr_s && (bus.address == ADDR_EDGE)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        cap_next_s = (cap_r & ~clr_s) | edge_s;

        if (!IRQ_ON) begin
            mask_next_s = {WIDTH{1'b0}};
        end else if (wr_s && (bus.address == ADDR_MASK)) begin
            mask_next_s = bus.writedata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end

        irq_next_s = IRQ_ON && (|(cap_r & mask_r));
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        case (bus.address)
            ADDR_DATA: rd_next_s = 32'(sync_in_s);
            ADDR_RSVD: rd_next_s = 32'h0;
            ADDR_MASK: rd_next_s = 32'(mask_r);
            ADDR_EDGE: rd_next_s = 32'(cap_r);
            default:   rd_next_s = 32'h0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_r <= 3'd0;
            cap_r   <= {WIDTH{1'b0}};
            mask_r  <= {WIDTH{1'b0}};
            rd_r    <= 32'h0;
            irq_r   <= 1'b0;
        end else begin
            prime_r <= primed_s ? prime_r : (prime_r + 3'd1);
            cap_r   <= cap_next_s;
            mask_r  <= mask_next_s;
            rd_r    <= rd_next_s;
            irq_r   <= irq_next_s;
        end
    end

    assign bus.readdata = rd_r;
    assign bus.irq      = irq_r;

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// Randomised bench for three PIO configurations against a delay-history model.
module tb_nios2_pio_in_edge;

    localparam int N = 3;
    localparam int PW [N] = '{16, 16, 8};
    localparam int PS [N] = '{2, 3, 4};
    localparam int PE [N] = '{0, 2, 1};
    localparam int PI [N] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [15:0] inp;

    logic [31:0] rd_w  [N];
    logic        irq_w [N];

    logic [31:0] m_cap  [N];
    logic [31:0] m_mask [N];
    logic [31:0] m_rd   [N];
    logic        m_irq  [N];
    logic [15:0] samp [$];
    int          cyc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_pio_in_edge_if bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign bus[g].address    = address;
        assign bus[g].chipselect = cs;
        assign bus[g].write_n    = wn;
        assign bus[g].writedata  = wd;
        assign rd_w[g]           = bus[g].readdata;
        assign irq_w[g]          = bus[g].irq;
    end

    nios2_pio_in_edge #(.WIDTH(PW[0]), .SYNC_STAGES(PS[0]), .EDGE_TYPE(PE[0]), .IRQ_EN(PI[0]))
        dut0 (.clk(clk), .reset(reset), .bus(bus[0]), .in_port(inp));
    nios2_pio_in_edge #(.WIDTH(PW[1]), .SYNC_STAGES(PS[1]), .EDGE_TYPE(PE[1]), .IRQ_EN(PI[1]))
        dut1 (.clk(clk), .reset(reset), .bus(bus[1]), .in_port(inp));
    nios2_pio_in_edge #(.WIDTH(PW[2]), .SYNC_STAGES(PS[2]), .EDGE_TYPE(PE[2]), .IRQ_EN(PI[2]))
        dut2 (.clk(clk), .reset(reset), .bus(bus[2]), .in_port(inp[7:0]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int i);
        return (PW[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PW[i]) - 32'd1);
    endfunction

    // Synchronised input seen after non-reset edge k: the sample taken SYNC_STAGES-1 edges earlier.
    function automatic logic [31:0] sin_at(input int i, input int k);
        int idx;
        idx = k - PS[i];
        if (idx >= 0 && idx < samp.size()) return 32'(samp[idx]) & wmask(i);
        return 32'h0;
    endfunction

    task automatic step();
        logic [31:0] n_cap [N];
        logic [31:0] n_mask [N];
        logic [31:0] n_rd [N];
        logic        n_irq [N];
        logic [31:0] cur, prev, ed, clr;
        logic        wr;
        wr = cs && !wn;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                n_cap[i] = 32'h0; n_mask[i] = 32'h0; n_rd[i] = 32'h0; n_irq[i] = 1'b0;
            end else begin
                cur  = sin_at(i, cyc);
                prev = sin_at(i, cyc - 1);
                case (PE[i])
                    0:       ed = cur & ~prev;
                    1:       ed = ~cur & prev;
                    default: ed = cur ^ prev;
                endcase
                ed = ed & wmask(i);
                if (cyc < PS[i] + 1) ed = 32'h0;
                clr = (wr && address == 2'd3) ? (wd & wmask(i)) : 32'h0;
                n_cap[i]  = (m_cap[i] & ~clr) | ed;
                n_mask[i] = (PI[i] == 0) ? 32'h0 :
                            ((wr && address == 2'd2) ? (wd & wmask(i)) : m_mask[i]);
                n_irq[i]  = (PI[i] != 0) && ((m_cap[i] & m_mask[i]) != 32'h0);
                case (address)
                    2'd0:    n_rd[i] = cur;
                    2'd2:    n_rd[i] = m_mask[i];
                    2'd3:    n_rd[i] = m_cap[i];
                    default: n_rd[i] = 32'h0;
                endcase
            end
        end
        if (reset) begin
            cyc = 0;
            samp.delete();
        end else begin
            samp.push_back(inp);
            cyc++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            m_cap[i] = n_cap[i]; m_mask[i] = n_mask[i]; m_rd[i] = n_rd[i]; m_irq[i] = n_irq[i];
            check_val($sformatf("rd%0d", i), rd_w[i], m_rd[i]);
            check_val($sformatf("irq%0d", i), 32'(irq_w[i]), 32'(m_irq[i]));
        end
    endtask

    task automatic bus_op(input logic [1:0] a, input logic w, input logic [31:0] d);
        address = a; cs = w; wn = ~w; wd = d;
        step();
        cs = 1'b0; wn = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; cs = 1'b0; wn = 1'b1; wd = 32'h0; inp = 16'hFFFF;
        cyc = 0;
        step(); step();
        reset = 1'b0;

        // Input high through reset release: no capture, data reflects the input.
        address = 2'd3;
        for (int k = 0; k < 10; k++) step();
        check_val("t1_cap", rd_w[0], 32'h0);
        check_val("t1_irq", 32'(irq_w[0]), 32'h0);
        address = 2'd0;
        step();
        check_val("t1_data", rd_w[0], 32'h0000_FFFF);

        // Clear, then rising edge on bit0 with mask bit0.
        inp = 16'h0000;
        for (int k = 0; k < 8; k++) step();
        bus_op(2'd3, 1'b1, 32'hFFFF_FFFF);
        bus_op(2'd2, 1'b1, 32'h0000_0001);
        address = 2'd3;
        inp = 16'h0001;
        for (int k = 0; k < 5; k++) step();
        check_val("t2_cap", rd_w[0], 32'h1);
        check_val("t2_irq", 32'(irq_w[0]), 32'h1);
        bus_op(2'd3, 1'b1, 32'h1);
        step();
        check_val("t2_irq_clr", 32'(irq_w[0]), 32'h0);

        // Rising edge on bit3 coincides with a clear of bit3.
        bus_op(2'd3, 1'b1, 32'hFFFF_FFFF);
        address = 2'd3;
        for (int k = 0; k < 6; k++) step();
        inp = 16'h0009;
        step(); step();
        bus_op(2'd3, 1'b1, 32'h8);
        address = 2'd3;
        step();
        check_val("t3_set_wins", rd_w[0] & 32'h8, 32'h8);

        // Width truncation on the mask and reserved / data write behaviour.
        bus_op(2'd2, 1'b1, 32'hFFFF_FFFF);
        address = 2'd2;
        step();
        check_val("t5_mask8", rd_w[2], 32'h0000_00FF);
        check_val("t5_mask16", rd_w[0], 32'h0000_FFFF);
        check_val("t5_mask_irqoff", rd_w[1], 32'h0);
        address = 2'd1;
        step();
        check_val("t5_rsvd", rd_w[0], 32'h0);
        bus_op(2'd0, 1'b1, 32'h1234_5678);
        bus_op(2'd1, 1'b1, 32'hFFFF_FFFF);

        // Falling edge on bit15 for the any-edge configuration.
        inp = 16'h8000;
        for (int k = 0; k < 8; k++) step();
        bus_op(2'd3, 1'b1, 32'hFFFF_FFFF);
        inp = 16'h0000;
        address = 2'd3;
        for (int k = 0; k < 7; k++) step();
        check_val("t4_any", rd_w[1], 32'h0000_8000);

        // Randomised traffic with occasional mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) inp = 16'($urandom);
            address = 2'($urandom_range(0, 3));
            cs      = ($urandom_range(0, 3) == 0);
            wn      = ($urandom_range(0, 1) == 0);
            wd      = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15));
            reset   = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; cs = 1'b0; wn = 1'b1;

        // Reset with pending capture and irq set.
        bus_op(2'd2, 1'b1, 32'hFFFF_FFFF);
        inp = 16'h0000;
        for (int k = 0; k < 8; k++) step();
        inp = 16'hA5A5;
        address = 2'd3;
        for (int k = 0; k < 8; k++) step();
        check_val("t6_pre_irq", 32'(irq_w[0]), 32'h1);
        reset = 1'b1;
        step();
        check_val("t6_rd", rd_w[0], 32'h0);
        check_val("t6_irq", 32'(irq_w[0]), 32'h0);
        reset = 1'b0;
        step();
        check_val("t6_cap", rd_w[0], 32'h0);
        address = 2'd2;
        step();
        check_val("t6_mask", rd_w[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
